ntt_scheduler: RTL and testbench

//  Shares one NTT engine (address generator + butterfly + coefficient RAM banks) among NUM_REQ polynomial slots.

---
 rtl/ntt_pkg.sv | 31 +++
 rtl/ntt_scheduler_rr_arbiter.sv | 33 +++
 rtl/ntt_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ntt_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT job scheduler and its round-robin arbiter.
package ntt_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int INV128  = 3303;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SCALE  = 3'd4,
        ST_SDRAIN = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic int ntt_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; returns one-hot and index.
module rr_arbiter import ntt_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [SEL_W-1:0]   gnt_idx
);

    int   idx_s;
    logic found_s;

    // Scan NUM_REQ positions starting at ptr and keep the first hit.
    always_comb begin
        gnt_oh  = {NUM_REQ{1'b0}};
        gnt_idx = {SEL_W{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = (int'(ptr) + i) % NUM_REQ;
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                gnt_idx        = SEL_W'(idx_s);
                gnt_oh[idx_s]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ntt_scheduler.sv
// Time-shares one NTT engine among NUM_REQ slots; INVNTT_SCALE_EN adds the 1/128 scaling sweep
// (multiply by INV128 mod KYBER_Q) after inverse jobs.
module ntt_scheduler import ntt_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = ntt_clog2(NUM_REQ),
    parameter int PIPE_LAT = 4
`ifdef INVNTT_SCALE_EN
    ,
    parameter int POLY_N   = KYBER_N
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_is_ntt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               eng_start,
    output logic               eng_is_ntt,
    output logic [SEL_W-1:0]   eng_sel,
    input  logic               eng_finished,
    output logic               scale_en,
    output logic [7:0]         scale_addr,
    output logic               err
);

    localparam logic [7:0] CNT_LOAD = 8'(PIPE_LAT - 1);

    state_t             state_r;
    state_t             state_s;
    logic [NUM_REQ-1:0] arb_oh_s;
    logic [SEL_W-1:0]   arb_idx_s;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [7:0]         cnt_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] done_r;
    logic [SEL_W-1:0]   eng_sel_r;
    logic               eng_is_ntt_r;
    logic               eng_start_r;
    logic               busy_r;
    logic               err_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr_r),
        .gnt_oh  (arb_oh_s),
        .gnt_idx (arb_idx_s)
    );

`ifdef INVNTT_SCALE_EN
    localparam logic [7:0] LAST_ADDR = 8'(POLY_N - 1);
    logic       scale_en_r;
    logic [7:0] scale_addr_r;
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) state_s = ST_START;
                else      state_s = ST_IDLE;
            end
            ST_START: state_s = ST_RUN;
            ST_RUN: begin
                if (eng_finished) state_s = ST_DRAIN;
                else              state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (cnt_r == 8'd0) begin
`ifdef INVNTT_SCALE_EN
                    if (!eng_is_ntt_r) state_s = ST_SCALE;
                    else               state_s = ST_DONE;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_DRAIN;
                end
            end
`ifdef INVNTT_SCALE_EN
            ST_SCALE: begin
                if (scale_addr_r == LAST_ADDR) state_s = ST_SDRAIN;
                else                           state_s = ST_SCALE;
            end
            ST_SDRAIN: begin
                if (cnt_r == 8'd0) state_s = ST_DONE;
                else               state_s = ST_SDRAIN;
            end
`endif
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, job ownership, drain counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {SEL_W{1'b0}};
            cnt_r        <= 8'd0;
            gnt_r        <= {NUM_REQ{1'b0}};
            done_r       <= {NUM_REQ{1'b0}};
            eng_sel_r    <= {SEL_W{1'b0}};
            eng_is_ntt_r <= 1'b0;
            eng_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            eng_start_r <= (state_r == ST_IDLE) && (state_s == ST_START);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE) ? gnt_r : {NUM_REQ{1'b0}};

            // Direction and owner are frozen at grant; later req/req_is_ntt changes do not matter.
            if ((state_r == ST_IDLE) && (state_s == ST_START)) begin
                gnt_r        <= arb_oh_s;
                eng_sel_r    <= arb_idx_s;
                eng_is_ntt_r <= req_is_ntt[arb_idx_s];
            end else if (state_r == ST_DONE) begin
                gnt_r        <= {NUM_REQ{1'b0}};
                eng_sel_r    <= {SEL_W{1'b0}};
                eng_is_ntt_r <= 1'b0;
                rr_ptr_r     <= (eng_sel_r == SEL_W'(NUM_REQ - 1)) ? {SEL_W{1'b0}}
                                                                   : eng_sel_r + SEL_W'(1);
            end else begin
                gnt_r <= gnt_r;
            end

            if ((state_r == ST_RUN) && eng_finished) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_SCALE) && (state_s == ST_SDRAIN)) begin
                cnt_r <= CNT_LOAD;
            end else if (((state_r == ST_DRAIN) || (state_r == ST_SDRAIN)) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (eng_finished && (state_r != ST_RUN)) err_r <= 1'b1;
            else                                     err_r <= err_r;
        end
    end

`ifdef INVNTT_SCALE_EN
    // Scaler sweep: one coefficient address per cycle while in SCALE.
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_en_r   <= 1'b0;
            scale_addr_r <= 8'd0;
        end else begin
            scale_en_r   <= (state_s == ST_SCALE);
            scale_addr_r <= ((state_r == ST_SCALE) && (state_s == ST_SCALE)) ? scale_addr_r + 8'd1 : 8'd0;
        end
    end

    assign scale_en   = scale_en_r;
    assign scale_addr = scale_addr_r;
`else
    assign scale_en   = 1'b0;
    assign scale_addr = 8'd0;
`endif

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign eng_start  = eng_start_r;
    assign eng_sel    = eng_sel_r;
    assign eng_is_ntt = eng_is_ntt_r;
    assign err        = err_r;

endmodule

// File: tb/tb_ntt_scheduler.sv
// Table-driven bench for ntt_scheduler with a done-slot scoreboard; adapts to INVNTT_SCALE_EN.
module tb_ntt_scheduler;

    localparam int PIPE_LAT = 4;
    localparam int POLY_N   = 256;
`ifdef INVNTT_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_is_ntt;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic       eng_start;
    logic       eng_is_ntt;
    logic [1:0] eng_sel;
    logic       eng_finished;
    logic       scale_en;
    logic [7:0] scale_addr;
    logic       err;

    int tests = 0;
    int fails = 0;
    int sb_q[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] is_ntt;
        int         exp_slot;
        int         delay;
        bit         drop;
    } vec_t;

    vec_t vecs[11];

    ntt_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_is_ntt   (req_is_ntt),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .eng_start    (eng_start),
        .eng_is_ntt   (eng_is_ntt),
        .eng_sel      (eng_sel),
        .eng_finished (eng_finished),
        .scale_en     (scale_en),
        .scale_addr   (scale_addr),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({gnt, done, busy, eng_start, eng_is_ntt, eng_sel, scale_en, scale_addr, err}), 0);
    endtask

    task automatic run_job(input vec_t v);
        int         wait_n;
        int         k;
        int         scount;
        int         lat_exp;
        bit         seen;
        bit         addr_bad;
        bit         gnt_bad;
        bit         exp_dir;
        logic [3:0] exp_gnt;
        exp_gnt = 4'b0001 << v.exp_slot;
        exp_dir = v.is_ntt[v.exp_slot];
        req        = v.req;
        req_is_ntt = v.is_ntt;
        sb_q.push_back(v.exp_slot);
        wait_n = 0;
        seen   = 1'b0;
        while (!seen && wait_n < 50) begin
            step();
            wait_n++;
            seen = eng_start;
        end
        chk("grant_wait", wait_n, 1);
        chk("gnt", int'(gnt), int'(exp_gnt));
        chk("eng_sel", int'(eng_sel), v.exp_slot);
        chk("eng_is_ntt", int'(eng_is_ntt), int'(exp_dir));
        chk("busy", int'(busy), 1);
        req_is_ntt = ~v.is_ntt;
        step();
        chk("start_single", int'(eng_start), 0);
        if (v.drop) req[v.exp_slot] = 1'b0;
        gnt_bad = 1'b0;
        for (int i = 1; i < v.delay; i++) begin
            step();
            if (eng_start || gnt != exp_gnt) gnt_bad = 1'b1;
        end
        eng_finished = 1'b1;
        step();
        eng_finished = 1'b0;
        lat_exp  = (SCALE_ON && !exp_dir) ? (2 * PIPE_LAT + 1 + POLY_N) : (PIPE_LAT + 1);
        k        = 0;
        scount   = 0;
        addr_bad = 1'b0;
        seen     = 1'b0;
        while (!seen && k < 1000) begin
            step();
            k++;
            if (scale_en) begin
                if (int'(scale_addr) != scount) addr_bad = 1'b1;
                scount++;
            end else if (scale_addr != 8'd0) begin
                addr_bad = 1'b1;
            end
            if (gnt != exp_gnt) gnt_bad = 1'b1;
            seen = |done;
        end
        chk("done_latency", k + 1, lat_exp);
        chk("scale_cycles", scount, (SCALE_ON && !exp_dir) ? POLY_N : 0);
        chk("scale_addr_seq", int'(addr_bad), 0);
        chk("gnt_hold", int'(gnt_bad), 0);
        if (sb_q.size() > 0) chk("done_slot", int'(done), int'(4'b0001 << sb_q.pop_front()));
        else                 chk("scoreboard_underflow", sb_q.size(), 1);
        step();
        chk("done_pulse", int'(done), 0);
        chk("gnt_idle", int'(gnt), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        bit stray;
        int n;
        vecs[0]  = '{4'b1111, 4'b0101, 0, 3,  1'b0};
        vecs[1]  = '{4'b1111, 4'b0101, 1, 5,  1'b0};
        vecs[2]  = '{4'b1111, 4'b0101, 2, 2,  1'b0};
        vecs[3]  = '{4'b1111, 4'b0101, 3, 4,  1'b0};
        vecs[4]  = '{4'b1111, 4'b0101, 0, 1,  1'b0};
        vecs[5]  = '{4'b0001, 4'b1111, 0, 10, 1'b0};
        vecs[6]  = '{4'b1100, 4'b1011, 2, 6,  1'b0};
        vecs[7]  = '{4'b0110, 4'b0000, 1, 2,  1'b0};
        vecs[8]  = '{4'b0010, 4'b1111, 1, 4,  1'b1};
        vecs[9]  = '{4'b1010, 4'b1000, 3, 3,  1'b0};
        vecs[10] = '{4'b0001, 4'b0001, 0, 2,  1'b0};

        rst          = 1'b1;
        req          = 4'b0000;
        req_is_ntt   = 4'b0000;
        eng_finished = 1'b0;
        repeat (3) step();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        step();
        chk_all_zero("idle_after_reset");

        // Stray engine completion while idle.
        eng_finished = 1'b1;
        step();
        eng_finished = 1'b0;
        chk("err_set", int'(err), 1);
        repeat (3) step();
        chk("err_held", int'(err), 1);
        chk("idle_no_gnt", int'({gnt, busy, eng_start}), 0);

        for (int i = 0; i < 11; i++) run_job(vecs[i]);
        chk("err_sticky", int'(err), 1);

        // Abandon a slot-2 job with reset (mid-SCALE when scaling is built in).
        req        = 4'b0100;
        req_is_ntt = 4'b0000;
        n = 0;
        while (!eng_start && n < 50) begin
            step();
            n++;
        end
        step();
        if (SCALE_ON) begin
            eng_finished = 1'b1;
            step();
            eng_finished = 1'b0;
            n = 0;
            while (!scale_en && n < 50) begin
                step();
                n++;
            end
            repeat (20) step();
        end else begin
            repeat (3) step();
        end
        rst   = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done != 4'b0000) stray = 1'b1;
            chk_all_zero("reset_mid_job");
        end
        req = 4'b0000;
        rst = 1'b0;
        step();
        if (done != 4'b0000) stray = 1'b1;
        chk("no_stray_done", int'(stray), 0);
        run_job('{4'b1111, 4'b0101, 0, 3, 1'b0});

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
